// File: rtl/rc4_message_checker.sv
// Scans the decrypted-message RAM and judges a trial RC4 key: pass iff every byte is 'a'..'z' or space.
// Define CHECKER_EARLY_EXIT_EN to stop scanning at the first failing byte.
module rc4_message_checker #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Check_Start,
  input  logic              Check_Ack,
  output logic [ADDR_W-1:0] Dec_Addr,
  input  logic [7:0]        Dec_Data,
  output logic              Checker_Finish,
  output logic              Key_Valid,
  output logic [ADDR_W-1:0] Fail_Index
);

`ifdef CHECKER_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CHECK,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fail_index_q, fail_index_d;
  logic              fail_q, fail_d;
  logic              finish_q, finish_d;
  logic              valid_q, valid_d;
  logic              byte_ok;
  logic              fail_now;

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    addr_d       = addr_q;
    fail_index_d = fail_index_q;
    fail_d       = fail_q;
    finish_d     = finish_q;
    valid_d      = valid_q;
    byte_ok      = ((Dec_Data >= 8'h61) && (Dec_Data <= 8'h7A)) || (Dec_Data == 8'h20);
    fail_now     = 1'b0;

    case (state_q)
      IDLE: begin
        index_d      = '0;
        addr_d       = '0;
        fail_d       = 1'b0;
        fail_index_d = '0;
        finish_d     = 1'b0;
        valid_d      = 1'b0;
        if (Check_Start) state_d = READ;
      end
      READ: begin
        addr_d  = index_q;
        state_d = CHECK;
      end
      CHECK: begin
        fail_now = !byte_ok;
        fail_d   = fail_q | fail_now;
        // Only the first failing index is recorded.
        if (fail_now && !fail_q) fail_index_d = index_q;
        if ((index_q == LAST_INDEX) || (EARLY_EXIT && fail_now)) begin
          state_d  = DONE;
          finish_d = 1'b1;
          valid_d  = !(fail_q | fail_now);
        end else begin
          index_d = index_q + ADDR_W'(1);
          addr_d  = index_q + ADDR_W'(1);
          state_d = READ;
        end
      end
      DONE: begin
        if (Check_Ack) begin
          state_d      = IDLE;
          index_d      = '0;
          addr_d       = '0;
          fail_d       = 1'b0;
          fail_index_d = '0;
          finish_d     = 1'b0;
          valid_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      index_q      <= '0;
      addr_q       <= '0;
      fail_index_q <= '0;
      fail_q       <= 1'b0;
      finish_q     <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      addr_q       <= addr_d;
      fail_index_q <= fail_index_d;
      fail_q       <= fail_d;
      finish_q     <= finish_d;
      valid_q      <= valid_d;
    end
  end

  assign Dec_Addr       = addr_q;
  assign Checker_Finish = finish_q;
  assign Key_Valid      = valid_q;
  assign Fail_Index     = fail_index_q;

endmodule

// File: tb/tb_rc4_message_checker.sv
// Self-checking bench for rc4_message_checker: table-driven boundary bytes plus scoreboarded scans.
// Honours CHECKER_EARLY_EXIT_EN when predicting verdict latency.
module tb_rc4_message_checker;
  localparam int MSG_LEN = 32;
  localparam int ADDR_W  = 5;
`ifdef CHECKER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              Check_Start = 1'b0;
  logic              Check_Ack = 1'b0;
  logic [ADDR_W-1:0] Dec_Addr;
  logic [7:0]        Dec_Data;
  logic              Checker_Finish;
  logic              Key_Valid;
  logic [ADDR_W-1:0] Fail_Index;
  logic [7:0]        mem [MSG_LEN];

  typedef struct {
    logic [7:0] data;
    logic       exp_valid;
  } vec_t;

  typedef struct {
    logic              valid;
    logic [ADDR_W-1:0] fidx;
    int                latency;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rc4_message_checker #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .Check_Start(Check_Start),
    .Check_Ack(Check_Ack),
    .Dec_Addr(Dec_Addr),
    .Dec_Data(Dec_Data),
    .Checker_Finish(Checker_Finish),
    .Key_Valid(Key_Valid),
    .Fail_Index(Fail_Index)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model with one-cycle read latency.
  always @(posedge clk) Dec_Data <= mem[Dec_Addr];

  function automatic int expLatency(input logic valid, input int fidx);
    if (!valid && EARLY) return 2 * fidx + 3;
    return 2 * MSG_LEN + 1;
  endfunction

  task automatic fillMem(input logic [7:0] b);
    for (int i = 0; i < MSG_LEN; i++) mem[i] = b;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_finish"}, 32'(Checker_Finish), 0);
    checkOutput({tag, "_key_valid"}, 32'(Key_Valid), 0);
    checkOutput({tag, "_fail_index"}, 32'(Fail_Index), 0);
    checkOutput({tag, "_dec_addr"}, 32'(Dec_Addr), 0);
  endtask

  // Counts edges after the start edge; the value seen at negedge n is the value sampled at edge n.
  task automatic waitVerdict(input bit check_addr, input int ack_at);
    int   n;
    bit   seen;
    exp_t e;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      Check_Ack = (n == ack_at);
      if (Checker_Finish) begin
        seen = 1'b1;
      end else begin
        checkOutput("kv_without_finish", 32'(Key_Valid), 0);
        if (check_addr) checkOutput("dec_addr_seq", 32'(Dec_Addr), 32'((n - 1) / 2));
      end
    end
    Check_Ack = 1'b0;
    e = sb.pop_front();
    checkOutput("finish_timeout", 32'(seen), 1);
    checkOutput("latency", 32'(n), 32'(e.latency));
    checkOutput("key_valid", 32'(Key_Valid), 32'(e.valid));
    checkOutput("fail_index", 32'(Fail_Index), 32'(e.fidx));
  endtask

  task automatic applyStimulus(input logic exp_valid, input logic [ADDR_W-1:0] exp_fidx,
                               input bit check_addr, input int ack_at);
    exp_t e;
    e.valid   = exp_valid;
    e.fidx    = exp_fidx;
    e.latency = expLatency(exp_valid, int'(exp_fidx));
    sb.push_back(e);
    @(negedge clk);
    Check_Start = 1'b1;
    @(posedge clk);
    #1 Check_Start = 1'b0;
    waitVerdict(check_addr, ack_at);
  endtask

  task automatic releaseAck();
    @(negedge clk);
    Check_Ack = 1'b1;
    @(negedge clk);
    Check_Ack = 1'b0;
    checkIdleOutputs("release");
  endtask

  initial begin
    vecs[0] = '{8'h20, 1'b1};
    vecs[1] = '{8'h61, 1'b1};
    vecs[2] = '{8'h7A, 1'b1};
    vecs[3] = '{8'h1F, 1'b0};
    vecs[4] = '{8'h21, 1'b0};
    vecs[5] = '{8'h60, 1'b0};
    vecs[6] = '{8'h7B, 1'b0};

    fillMem(8'h61);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;

    $display("[TB] all-pass scan");
    applyStimulus(1'b1, '0, 1'b1, 0);
    releaseAck();

    $display("[TB] character-class boundaries");
    for (int i = 0; i < 7; i++) begin
      fillMem(8'h61);
      mem[0] = vecs[i].data;
      applyStimulus(vecs[i].exp_valid, '0, 1'b0, 0);
      releaseAck();
    end

    $display("[TB] two bad bytes");
    fillMem(8'h7A);
    mem[5]  = 8'h41;
    mem[20] = 8'h00;
    applyStimulus(1'b0, 5'd5, 1'b0, 0);
    releaseAck();

    $display("[TB] handshake");
    fillMem(8'h61);
    applyStimulus(1'b1, '0, 1'b0, 10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_finish", 32'(Checker_Finish), 1);
      checkOutput("hold_key_valid", 32'(Key_Valid), 1);
      checkOutput("hold_fail_index", 32'(Fail_Index), 0);
    end
    releaseAck();
    applyStimulus(1'b1, '0, 1'b1, 0);
    releaseAck();

    $display("[TB] reset mid-scan");
    fillMem(8'h61);
    @(negedge clk);
    Check_Start = 1'b1;
    @(posedge clk);
    #1 Check_Start = 1'b0;
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      Check_Start = (n == 10);
      if (n == 11) checkOutput("restart_ignored_addr11", 32'(Dec_Addr), 5);
      if (n == 19) checkOutput("scan_addr19", 32'(Dec_Addr), 9);
      if (n == 20) rst = 1'b1;
      if (n == 21) begin
        checkIdleOutputs("midreset");
        rst = 1'b0;
      end
    end
    applyStimulus(1'b1, '0, 1'b0, 0);
    releaseAck();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
